// File: rtl/pico_stream_pkg.sv
// Shared definitions for the pico stream endpoints: id field layout, beat geometry and the
// helper that builds a 9-bit stream id.
package pico_stream_pkg;

  localparam int unsigned ID_W        = 9;
  localparam int unsigned ID_DESC_BIT = 8;
  localparam int unsigned ID_DIR_BIT  = 7;
  localparam int unsigned STREAM_W    = 7;
  localparam int unsigned BEAT_W      = 128;
  localparam int unsigned BEAT_BYTES  = 16;

  typedef enum logic {
    KindData = 1'b0,
    KindDesc = 1'b1
  } id_kind_e;

  // Host-to-FPGA ids always carry direction=1.
  function automatic logic [ID_W-1:0] make_id(input id_kind_e kind,
                                               input logic [STREAM_W-1:0] stream);
    logic [ID_W-1:0] id;
    id = '0;
    id[ID_DESC_BIT]      = kind;
    id[ID_DIR_BIT]       = 1'b1;
    id[STREAM_W-1:0]     = stream;
    return id;
  endfunction

endpackage

// File: rtl/pico_stream_in_chan.sv
// One input stream channel: FWFT data FIFO, descriptor FIFO, flow-control sequence counters,
// sticky overflow flag and, with PICO_STREAM_IN_STATS_EN defined, a written-beat counter.
module pico_stream_in_chan
  import pico_stream_pkg::*;
#(
  parameter int unsigned DATA_DEPTH = 512,
  parameter int unsigned DESC_DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_push,
  input  logic              desc_push,
  input  logic [BEAT_W-1:0] wr_data,
  input  logic              data_pop_req,
  input  logic              desc_pop_req,
  output logic              rdy,
  output logic [BEAT_W-1:0] data,
  output logic [31:0]       data_seq,
  output logic [31:0]       desc_seq,
  output logic [BEAT_W-1:0] desc_head,
  output logic              desc_valid,
  output logic              overflow,
  output logic [31:0]       beats
);

  localparam int unsigned DAW = $clog2(DATA_DEPTH);
  localparam int unsigned SAW = $clog2(DESC_DEPTH);
  localparam logic [DAW:0] DATA_FULL_CNT = DATA_DEPTH[DAW:0];
  localparam logic [SAW:0] DESC_FULL_CNT = DESC_DEPTH[SAW:0];
  localparam logic [31:0]  DATA_SEQ_RST  = 32'(DATA_DEPTH * BEAT_BYTES);
  localparam logic [31:0]  DESC_SEQ_RST  = 32'(DESC_DEPTH * BEAT_BYTES);

  logic [BEAT_W-1:0] data_mem [DATA_DEPTH];
  logic [BEAT_W-1:0] desc_mem [DESC_DEPTH];

  logic [DAW-1:0] data_wr_q, data_rd_q;
  logic [DAW:0]   data_cnt_q;
  logic [SAW-1:0] desc_wr_q, desc_rd_q;
  logic [SAW:0]   desc_cnt_q;
  logic [31:0]    data_seq_q, desc_seq_q;
  logic           overflow_q;

  logic data_full, data_empty, data_wr, data_rd;
  logic desc_full, desc_empty, desc_wr, desc_rd;

  assign data_full  = (data_cnt_q == DATA_FULL_CNT);
  assign data_empty = (data_cnt_q == '0);
  assign desc_full  = (desc_cnt_q == DESC_FULL_CNT);
  assign desc_empty = (desc_cnt_q == '0);

  // A push into a full FIFO is dropped even if a pop happens in the same cycle.
  assign data_wr = data_push && !data_full;
  assign data_rd = data_pop_req && !data_empty;
  assign desc_wr = desc_push && !desc_full;
  assign desc_rd = desc_pop_req && !desc_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_wr_q  <= '0;
      data_rd_q  <= '0;
      data_cnt_q <= '0;
      desc_wr_q  <= '0;
      desc_rd_q  <= '0;
      desc_cnt_q <= '0;
      data_seq_q <= DATA_SEQ_RST;
      desc_seq_q <= DESC_SEQ_RST;
      overflow_q <= 1'b0;
    end else begin
      if (data_wr) data_wr_q <= data_wr_q + 1'b1;
      if (data_rd) data_rd_q <= data_rd_q + 1'b1;
      data_cnt_q <= data_cnt_q + {{DAW{1'b0}}, data_wr} - {{DAW{1'b0}}, data_rd};
      if (desc_wr) desc_wr_q <= desc_wr_q + 1'b1;
      if (desc_rd) desc_rd_q <= desc_rd_q + 1'b1;
      desc_cnt_q <= desc_cnt_q + {{SAW{1'b0}}, desc_wr} - {{SAW{1'b0}}, desc_rd};
      if (data_rd) data_seq_q <= data_seq_q + 32'(BEAT_BYTES);
      if (desc_rd) desc_seq_q <= desc_seq_q + 32'(BEAT_BYTES);
      if ((data_push && data_full) || (desc_push && desc_full)) overflow_q <= 1'b1;
    end
  end

  // Storage is not reset; outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (data_wr) data_mem[data_wr_q] <= wr_data;
    if (desc_wr) desc_mem[desc_wr_q] <= wr_data;
  end

  assign rdy        = !data_empty;
  assign data       = data_empty ? '0 : data_mem[data_rd_q];
  assign desc_valid = !desc_empty;
  assign desc_head  = desc_empty ? '0 : desc_mem[desc_rd_q];
  assign data_seq   = data_seq_q;
  assign desc_seq   = desc_seq_q;
  assign overflow   = overflow_q;

`ifdef PICO_STREAM_IN_STATS_EN
  logic [31:0] beats_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beats_q <= '0;
    end else if (data_wr) begin
      beats_q <= beats_q + 32'd1;
    end
  end

  assign beats = beats_q;
`else
  assign beats = '0;
`endif

endmodule

// File: rtl/pico_stream_in_mc.sv
// Multi-channel host-to-FPGA stream input endpoint: id decode, registered write/pop stage,
// NUM_CH channel instances and the registered poll mux. Optional macro: PICO_STREAM_IN_STATS_EN.
module pico_stream_in_mc
  import pico_stream_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned BASE_ID    = 1,
  parameter int unsigned DATA_DEPTH = 512,
  parameter int unsigned DESC_DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [NUM_CH-1:0]        s_rdy,
  output logic [BEAT_W*NUM_CH-1:0] s_data,
  input  logic [NUM_CH-1:0]        s_en,
  input  logic                     s_in_valid,
  input  logic [ID_W-1:0]          s_in_id,
  input  logic [BEAT_W-1:0]        s_in_data,
  input  logic [ID_W-1:0]          s_poll_id,
  output logic [31:0]              s_poll_seq,
  output logic [BEAT_W-1:0]        s_poll_next_desc,
  output logic                     s_poll_next_desc_valid,
  output logic [31:0]              s_poll_beats,
  input  logic [ID_W-1:0]          s_next_desc_rd_id,
  input  logic                     s_next_desc_rd_en,
  output logic [NUM_CH-1:0]        s_overflow
);

  logic [NUM_CH-1:0] in_data_hit, in_desc_hit, rd_hit, poll_data_hit, poll_desc_hit;
  logic [NUM_CH-1:0] data_push_q, desc_push_q, desc_pop_q;
  logic [BEAT_W-1:0] wr_data_q;

  logic [31:0]       ch_data_seq  [NUM_CH];
  logic [31:0]       ch_desc_seq  [NUM_CH];
  logic [BEAT_W-1:0] ch_desc_head [NUM_CH];
  logic              ch_desc_vld  [NUM_CH];
  logic [31:0]       ch_beats     [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : gen_ch
    localparam logic [STREAM_W-1:0] STREAM = STREAM_W'(BASE_ID + k);
    logic [ID_W-1:0] data_id, desc_id;

    assign data_id = make_id(KindData, STREAM);
    assign desc_id = make_id(KindDesc, STREAM);

    assign in_data_hit[k]   = s_in_valid && (s_in_id == data_id);
    assign in_desc_hit[k]   = s_in_valid && (s_in_id == desc_id);
    assign rd_hit[k]        = s_next_desc_rd_en && (s_next_desc_rd_id == data_id);
    assign poll_data_hit[k] = (s_poll_id == data_id);
    assign poll_desc_hit[k] = (s_poll_id == desc_id);

    pico_stream_in_chan #(
      .DATA_DEPTH (DATA_DEPTH),
      .DESC_DEPTH (DESC_DEPTH)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .data_push    (data_push_q[k]),
      .desc_push    (desc_push_q[k]),
      .wr_data      (wr_data_q),
      .data_pop_req (s_en[k]),
      .desc_pop_req (desc_pop_q[k]),
      .rdy          (s_rdy[k]),
      .data         (s_data[BEAT_W*k +: BEAT_W]),
      .data_seq     (ch_data_seq[k]),
      .desc_seq     (ch_desc_seq[k]),
      .desc_head    (ch_desc_head[k]),
      .desc_valid   (ch_desc_vld[k]),
      .overflow     (s_overflow[k]),
      .beats        (ch_beats[k])
    );
  end

  // Write beats and descriptor pop requests take one register stage before reaching a FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_push_q <= '0;
      desc_push_q <= '0;
      desc_pop_q  <= '0;
      wr_data_q   <= '0;
    end else begin
      data_push_q <= in_data_hit;
      desc_push_q <= in_desc_hit;
      desc_pop_q  <= rd_hit;
      if (s_in_valid) wr_data_q <= s_in_data;
    end
  end

  logic [31:0]       poll_seq_d, poll_seq_q;
  logic [BEAT_W-1:0] poll_desc_d, poll_desc_q;
  logic              poll_vld_d, poll_vld_q;
  logic [31:0]       poll_beats_d, poll_beats_q;

  always_comb begin
    poll_seq_d   = '0;
    poll_desc_d  = '0;
    poll_vld_d   = 1'b0;
    poll_beats_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (poll_desc_hit[k]) begin
        poll_seq_d = ch_desc_seq[k];
      end
      if (poll_data_hit[k]) begin
        poll_seq_d   = ch_data_seq[k];
        poll_desc_d  = ch_desc_head[k];
        poll_vld_d   = ch_desc_vld[k];
        poll_beats_d = ch_beats[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poll_seq_q   <= '0;
      poll_desc_q  <= '0;
      poll_vld_q   <= 1'b0;
      poll_beats_q <= '0;
    end else begin
      poll_seq_q   <= poll_seq_d;
      poll_desc_q  <= poll_desc_d;
      poll_vld_q   <= poll_vld_d;
      poll_beats_q <= poll_beats_d;
    end
  end

  assign s_poll_seq             = poll_seq_q;
  assign s_poll_next_desc       = poll_desc_q;
  assign s_poll_next_desc_valid = poll_vld_q;
  assign s_poll_beats           = poll_beats_q;

endmodule

// File: tb/tb_pico_stream_in_mc.sv
// Directed bench for pico_stream_in_mc (NUM_CH=4, BASE_ID=1, DATA_DEPTH=512, DESC_DEPTH=32).
module tb_pico_stream_in_mc;

  logic         clk;
  logic         rst;
  logic [3:0]   s_rdy;
  logic [511:0] s_data;
  logic [3:0]   s_en;
  logic         s_in_valid;
  logic [8:0]   s_in_id;
  logic [127:0] s_in_data;
  logic [8:0]   s_poll_id;
  logic [31:0]  s_poll_seq;
  logic [127:0] s_poll_next_desc;
  logic         s_poll_next_desc_valid;
  logic [31:0]  s_poll_beats;
  logic [8:0]   s_next_desc_rd_id;
  logic         s_next_desc_rd_en;
  logic [3:0]   s_overflow;

  int checks   = 0;
  int failures = 0;

  pico_stream_in_mc #(
    .NUM_CH     (4),
    .BASE_ID    (1),
    .DATA_DEPTH (512),
    .DESC_DEPTH (32)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .s_rdy                  (s_rdy),
    .s_data                 (s_data),
    .s_en                   (s_en),
    .s_in_valid             (s_in_valid),
    .s_in_id                (s_in_id),
    .s_in_data              (s_in_data),
    .s_poll_id              (s_poll_id),
    .s_poll_seq             (s_poll_seq),
    .s_poll_next_desc       (s_poll_next_desc),
    .s_poll_next_desc_valid (s_poll_next_desc_valid),
    .s_poll_beats           (s_poll_beats),
    .s_next_desc_rd_id      (s_next_desc_rd_id),
    .s_next_desc_rd_en      (s_next_desc_rd_en),
    .s_overflow             (s_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [127:0] q0[$];
  logic [127:0] q1[$];
  logic [127:0] e;
  logic [127:0] desc_d;
  logic [31:0]  exp_beats;

  initial begin
    rst = 1'b1;
    s_en = '0;
    s_in_valid = 1'b0;
    s_in_id = '0;
    s_in_data = '0;
    s_poll_id = '0;
    s_next_desc_rd_id = '0;
    s_next_desc_rd_en = 1'b0;
    desc_d = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C;

    // Reset state.
    repeat (3) tick();
    check("rst_rdy", 128'(s_rdy), 128'h0);
    check("rst_ovf", 128'(s_overflow), 128'h0);
    check("rst_poll_seq", 128'(s_poll_seq), 128'h0);
    rst = 1'b0;

    s_poll_id = 9'h081;
    tick();
    check("rst_data_seq", 128'(s_poll_seq), 128'h2000);
    check("rst_data_vld", 128'(s_poll_next_desc_valid), 128'h0);
    s_poll_id = 9'h181;
    tick();
    check("rst_desc_seq", 128'(s_poll_seq), 128'h200);
    check("rst_desc_vld", 128'(s_poll_next_desc_valid), 128'h0);
    check("rst_beats", 128'(s_poll_beats), 128'h0);
    s_poll_id = 9'h085;
    tick();
    check("nomatch_seq", 128'(s_poll_seq), 128'h0);

    // Three beats to channel 2 (stream 3), first-word-fall-through at t+2.
    s_in_valid = 1'b1;
    s_in_id = 9'h083;
    s_in_data = 128'hA1;
    tick();
    check("wr_lat_t1", 128'(s_rdy), 128'h0);
    s_in_data = 128'hB2;
    tick();
    check("wr_lat_t2", 128'(s_rdy), 128'h4);
    check("wr_head_a", s_data[256 +: 128], 128'hA1);
    s_in_data = 128'hC3;
    tick();
    s_in_valid = 1'b0;
    s_en = 4'b0100;
    check("pop_a", s_data[256 +: 128], 128'hA1);
    tick();
    check("pop_b", s_data[256 +: 128], 128'hB2);
    tick();
    check("pop_c", s_data[256 +: 128], 128'hC3);
    tick();
    s_en = '0;
    check("pop_empty", 128'(s_rdy), 128'h0);
    s_poll_id = 9'h083;
    tick();
    check("data_seq_3", 128'(s_poll_seq), 128'h2030);
`ifdef PICO_STREAM_IN_STATS_EN
    exp_beats = 32'd3;
`else
    exp_beats = 32'd0;
`endif
    check("beats_ch2", 128'(s_poll_beats), 128'(exp_beats));

    // Descriptor to channel 1 (stream 2), then consume it.
    s_in_valid = 1'b1;
    s_in_id = 9'h182;
    s_in_data = desc_d;
    tick();
    s_in_valid = 1'b0;
    check("desc_not_data", 128'(s_rdy), 128'h0);
    tick();
    s_poll_id = 9'h082;
    tick();
    check("desc_head", s_poll_next_desc, desc_d);
    check("desc_vld", 128'(s_poll_next_desc_valid), 128'h1);
    check("desc_seq_data_poll", 128'(s_poll_seq), 128'h2000);
    s_next_desc_rd_id = 9'h082;
    s_next_desc_rd_en = 1'b1;
    tick();
    s_next_desc_rd_en = 1'b0;
    check("desc_pop_t1", 128'(s_poll_next_desc_valid), 128'h1);
    tick();
    s_poll_id = 9'h182;
    tick();
    check("desc_seq_pop", 128'(s_poll_seq), 128'h210);
    s_poll_id = 9'h082;
    tick();
    check("desc_vld_pop", 128'(s_poll_next_desc_valid), 128'h0);
    check("desc_head_pop", s_poll_next_desc, 128'h0);
    // Popping an empty descriptor FIFO leaves the sequence alone.
    s_next_desc_rd_en = 1'b1;
    tick();
    s_next_desc_rd_en = 1'b0;
    tick();
    tick();
    s_poll_id = 9'h182;
    tick();
    check("desc_seq_empty_pop", 128'(s_poll_seq), 128'h210);

    // Overfill channel 0 with 513 beats.
    s_in_valid = 1'b1;
    s_in_id = 9'h081;
    for (int i = 0; i < 513; i++) begin
      s_in_data = 128'(i);
      tick();
    end
    s_in_valid = 1'b0;
    tick();
    tick();
    check("ovf_flag", 128'(s_overflow), 128'h1);
    check("ovf_rdy", 128'(s_rdy), 128'h1);
    s_poll_id = 9'h081;
    tick();
`ifdef PICO_STREAM_IN_STATS_EN
    exp_beats = 32'd512;
`else
    exp_beats = 32'd0;
`endif
    check("beats_ch0", 128'(s_poll_beats), 128'(exp_beats));
    s_en = 4'b0001;
    for (int i = 0; i < 512; i++) begin
      check("ovf_drain", s_data[0 +: 128], 128'(i));
      tick();
    end
    s_en = '0;
    check("ovf_dropped", 128'(s_rdy), 128'h0);
    s_poll_id = 9'h081;
    tick();
    check("data_seq_512", 128'(s_poll_seq), 128'h4000);

    // Interleaved channels 0 and 1 with concurrent pops.
    for (int i = 0; i < 16; i++) begin
      s_in_valid = 1'b1;
      s_in_id = (i % 2 == 0) ? 9'h081 : 9'h082;
      s_in_data = (i % 2 == 0) ? 128'(32'h100 + i) : 128'(32'h200 + i);
      if (i % 2 == 0) q0.push_back(s_in_data);
      else q1.push_back(s_in_data);
      s_en = s_rdy & 4'b0011;
      if (s_en[0]) begin
        e = (q0.size() > 0) ? q0.pop_front() : '1;
        check("ilv_ch0", s_data[0 +: 128], e);
      end
      if (s_en[1]) begin
        e = (q1.size() > 0) ? q1.pop_front() : '1;
        check("ilv_ch1", s_data[128 +: 128], e);
      end
      tick();
    end
    s_in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      s_en = s_rdy & 4'b0011;
      if (s_en[0]) begin
        e = (q0.size() > 0) ? q0.pop_front() : '1;
        check("ilv_ch0", s_data[0 +: 128], e);
      end
      if (s_en[1]) begin
        e = (q1.size() > 0) ? q1.pop_front() : '1;
        check("ilv_ch1", s_data[128 +: 128], e);
      end
      tick();
    end
    s_en = '0;
    check("ilv_q0_left", 128'(q0.size()), 128'h0);
    check("ilv_q1_left", 128'(q1.size()), 128'h0);
    check("ilv_rdy", 128'(s_rdy), 128'h0);

    // Reset in the middle of a burst to channel 3 (stream 4).
    s_in_valid = 1'b1;
    s_in_id = 9'h084;
    s_in_data = 128'hAA;
    s_poll_id = 9'h084;
    tick();
    tick();
    tick();
    check("burst_rdy", 128'(s_rdy), 128'h8);
    check("burst_poll", 128'(s_poll_seq), 128'h2000);
    rst = 1'b1;
    #1;
    check("mid_rst_rdy", 128'(s_rdy), 128'h0);
    check("mid_rst_data", s_data[384 +: 128], 128'h0);
    check("mid_rst_poll", 128'(s_poll_seq), 128'h0);
    check("mid_rst_ovf", 128'(s_overflow), 128'h0);
    s_in_valid = 1'b0;
    tick();
    rst = 1'b0;
    s_poll_id = 9'h081;
    tick();
    check("post_rst_seq0", 128'(s_poll_seq), 128'h2000);
    check("post_rst_beats", 128'(s_poll_beats), 128'h0);
    s_poll_id = 9'h182;
    tick();
    check("post_rst_desc1", 128'(s_poll_seq), 128'h200);
    check("post_rst_rdy", 128'(s_rdy), 128'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pico_stream_in_mc.md
# pico_stream_in_mc

Multi-channel host-to-FPGA stream input endpoint: one block serves NUM_CH input streams sharing a single PCIe write bus, poll bus and descriptor-read bus. Each channel owns a data FIFO and a descriptor FIFO and advertises flow-control sequence numbers to the host DMA engine through the poll bus. It sits between the PCIe AXI bridge stream demux and user logic, replacing one single-stream endpoint per channel.

## Interface
- NUM_CH, 4: number of input streams (1..32).
- BASE_ID, 1: 7-bit stream number of channel 0; channel k answers to stream BASE_ID+k.
- DATA_DEPTH, 512: per-channel data FIFO depth in 128-bit beats (power of 2, ≥16).
- DESC_DEPTH, 32: per-channel descriptor FIFO depth (power of 2, ≥4).
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- s_rdy  out  NUM_CH  channel k has a beat available.
- s_data  out  128*NUM_CH  channel k head beat at bits [128k+127:128k].
- s_en  in  NUM_CH  channel k pops a beat; ignored while s_rdy[k]=0.
- s_in_valid  in  1  write beat present on the bus.
- s_in_id  in  9  {desc flag, direction=1, stream[6:0]}.
- s_in_data  in  128  write beat payload.
- s_poll_id  in  9  id being polled.
- s_poll_seq  out  32  sequence value of polled id.
- s_poll_next_desc  out  128  head descriptor of polled data id.
- s_poll_next_desc_valid  out  1  head descriptor present.
- s_poll_beats  out  32  beats written to polled channel (see Configuration).
- s_next_desc_rd_id  in  9  id whose descriptor is consumed.
- s_next_desc_rd_en  in  1  consume head descriptor.
- s_overflow  out  NUM_CH  sticky: write to full FIFO dropped.

## Operation
- Decode: data id = {0,1,BASE_ID+k}; desc id = {1,1,BASE_ID+k}. Ids matching no channel are ignored everywhere.
- Write: s_in_data and decoded channel/kind registered one cycle, then pushed into that channel's data or descriptor FIFO.
- Full FIFO on push: beat dropped, s_overflow[k] set; cleared only by rst.
- Data seq per channel: reset to DATA_DEPTH*16; +16 on every accepted s_en pop. Desc seq: reset to DESC_DEPTH*16; +16 on every descriptor pop. Both wrap mod 2^32.
- Descriptor pop: s_next_desc_rd_en with matching data id registers a pop request; popping an empty descriptor FIFO does nothing and does not advance desc seq.
- Poll, desc id match: s_poll_seq = desc seq, other poll outputs 0. Data id match: s_poll_seq = data seq, next_desc = head descriptor, valid = ~desc empty. No match: all poll outputs 0.
- Simultaneous push and pop on one FIFO: both take effect; occupancy unchanged.
- Reset: all outputs 0, FIFOs empty, seqs to reset values; asserting rst mid-transfer discards all contents.

## Timing
- s_in_valid at cycle t → FIFO write at t+1 → s_rdy[k]/s_data valid at t+2 (first-word-fall-through).
- s_en[k]&s_rdy[k] at t → next beat/s_rdy at t+1; data seq updated at t+1.
- Poll: s_poll_id at t → poll outputs registered at t+1, reflecting state at t.
- Descriptor pop: rd_en at t → FIFO pop at t+1 → desc seq and poll head updated at t+2. Back-to-back pops allowed.

## Configuration
- PICO_STREAM_IN_STATS_EN defined: per-channel 32-bit wrapping counter of accepted data-FIFO writes; s_poll_beats returns it on data-id poll, 0 otherwise; reset 0.
- Undefined: counters absent, s_poll_beats constant 0.

## Structure
- Package pico_stream_pkg: id field positions (desc flag bit 8, direction bit 7), BEAT_BYTES=16, id construction function.
- Sub-module pico_stream_in_chan: one channel (two FIFOs, seq counters, overflow, optional stats), generated NUM_CH times; top holds id decode and poll mux.

## Test plan
- Reset, NUM_CH=4: poll {0,1,1} → seq 0x2000; poll {1,1,1} → seq 0x200, valid 0; s_rdy=4'b0.
- Write 3 beats to id {0,1,3}, pop all on s_en[2] → data in order at t+2, seq 0x2000+48.
- Write descriptor D to {1,1,2}; poll {0,1,2} → next_desc=D, valid 1; rd_en id {0,1,2} → desc seq 0x210, valid 0.
- Fill channel 0 with 513 beats at DATA_DEPTH=512 → 512 stored, s_overflow=4'b0001, other channels unaffected.
- Interleaved writes to channels 0 and 1 with simultaneous pops → no loss, per-channel order preserved.
- Assert rst mid-burst → outputs 0 immediately, seqs back to reset values; with STATS_EN, s_poll_beats=0.
